// File: rtl/rf_pkg.sv
// Shared register-file types: default id/data widths and the port arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_REG_ID_LEN = 4;
  localparam int RF_REG_SIZE   = 64;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester searching from ptr upward, modulo N.
// Latency: combinational.
// Backpressure: none; grant is one-hot or zero, any_o flags a grant.
module rr_pick #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Walk the ring starting at ptr_i and stop at the first valid entry.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!any_o && valid_i[(int'(ptr_i) + off) % N]) begin
        any_o                              = 1'b1;
        grant_o[(int'(ptr_i) + off) % N]   = 1'b1;
        idx_o                              = W'((int'(ptr_i) + off) % N);
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one single-port register file among NREQ requesters, round-robin with optional lock.
// Latency: grant and file access same cycle; read response registered, one cycle later.
// Backpressure: valid/ready; at most one req_ready per cycle, none while in reset.
module rf_port_arbiter
  import rf_pkg::*;
#(
  parameter int REG_ID_LEN = RF_REG_ID_LEN,
  parameter int REG_SIZE   = RF_REG_SIZE,
  parameter int NREQ       = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ-1:0]            req_lock,
  input  logic [NREQ*REG_ID_LEN-1:0] req_id,
  input  logic [NREQ*REG_SIZE-1:0]   req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [REG_SIZE-1:0]        rsp_data,
  output logic [REG_ID_LEN-1:0]      rf_id,
  output logic                       rf_write,
  output logic [REG_SIZE-1:0]        rf_value,
  output logic                       rf_read,
  input  logic [REG_SIZE-1:0]        rf_out
);

  localparam int PW = $clog2(NREQ);

  arb_state_t          state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [REG_SIZE-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]     pick_gnt;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;

  logic                owner_hold;
  logic [NREQ-1:0]     gnt;
  logic [PW-1:0]       gidx;
  logic                gany;

  rr_pick #(.N(NREQ), .W(PW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant select: a locked owner that is still requesting wins outright; otherwise
  // round-robin. A locked owner that drops valid releases the lock this same cycle.
  always_comb begin
    owner_hold = (state_q == LOCKED) && req_valid[owner_q];
    gnt        = '0;
    gidx       = '0;
    gany       = 1'b0;
    if (rst_n) begin
      if (owner_hold) begin
        gnt[owner_q] = 1'b1;
        gidx         = owner_q;
        gany         = 1'b1;
      end else begin
        gnt  = pick_gnt;
        gidx = pick_idx;
        gany = pick_any;
      end
    end
  end

  // Register-file port mux driven from the granted requester; all zero when idle.
  always_comb begin
    rf_id    = '0;
    rf_value = '0;
    rf_write = 1'b0;
    rf_read  = 1'b0;
    if (gany) begin
      rf_id    = req_id[int'(gidx)*REG_ID_LEN +: REG_ID_LEN];
      rf_value = req_wdata[int'(gidx)*REG_SIZE +: REG_SIZE];
      rf_write = req_write[gidx];
      rf_read  = ~req_write[gidx];
    end
  end

  // Next state: lock tracking, pointer advance (frozen while the owner keeps the lock),
  // and capture of the combinational file output for a granted read.
  always_comb begin
    state_d     = ARB;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (gany) begin
      if (req_lock[gidx]) begin
        state_d = LOCKED;
        owner_d = gidx;
      end
      if (!(owner_hold && req_lock[gidx])) begin
        rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
      end
      if (!req_write[gidx]) begin
        rsp_valid_d = gnt;
        rsp_data_d  = rf_out;
      end
    end
  end

  // State registers with synchronous reset; an in-flight response is dropped by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: register-file model, per-cycle reference model and directed vectors.
// Latency: checks combinational outputs each cycle and responses one cycle after the read grant.
// Backpressure: stimulus holds requests static per cycle; the model decides which is accepted.
module tb_rf_port_arbiter;
  import rf_pkg::*;

  localparam int N  = 3;
  localparam int IW = 4;
  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_write, req_lock;
  logic [N*IW-1:0] req_id;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rf_id;
  logic            rf_write, rf_read;
  logic [DW-1:0]   rf_value, rf_out;

  logic [IW-1:0]   id_a [N];
  logic [DW-1:0]   wd_a [N];
  logic [DW-1:0]   mem  [16];

  int n_checks = 0;
  int n_err    = 0;

  rf_port_arbiter #(.REG_ID_LEN(IW), .REG_SIZE(DW), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_lock  (req_lock),
    .req_id    (req_id),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rf_id     (rf_id),
    .rf_write  (rf_write),
    .rf_value  (rf_value),
    .rf_read   (rf_read),
    .rf_out    (rf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_id    = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_id[i*IW +: IW]    = id_a[i];
      req_wdata[i*DW +: DW] = wd_a[i];
    end
  end

  // Register file: combinational read, write on the clock edge; reset reloads r[i] = i*0x1111.
  assign rf_out = mem[rf_id];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h1111 * i;
    end else if (rf_write) begin
      mem[rf_id] <= rf_value;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pointer, lock owner and pending response as plain integers.
  int          m_ptr = 0, m_owner = 0, n_ptr = 0, n_owner = 0;
  bit          m_locked = 0, m_init = 0, n_locked = 0, n_init = 0;
  logic [N-1:0]  m_rsp_v = '0, n_rsp_v = '0;
  logic [DW-1:0] m_rsp_d = '0, n_rsp_d = '0;
  int          g;
  logic [N-1:0]  e_rdy;

  always @(negedge clk) begin
    g = -1;
    if (rst_n) begin
      if (m_locked && req_valid[m_owner]) g = m_owner;
      else
        for (int off = 0; off < N; off++)
          if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
    end
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    chk("model ready", 64'(req_ready), 64'(e_rdy));
    chk("model rf_write", 64'(rf_write), (g >= 0) ? 64'(req_write[g]) : 64'd0);
    chk("model rf_read", 64'(rf_read), (g >= 0) ? 64'(!req_write[g]) : 64'd0);
    chk("model rf_id", 64'(rf_id), (g >= 0) ? 64'(id_a[g]) : 64'd0);
    chk("model rf_value", rf_value, (g >= 0) ? wd_a[g] : 64'd0);
    if (m_init) begin
      chk("model rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
      chk("model rsp_data", rsp_data, m_rsp_d);
    end
    if (!rst_n) begin
      n_ptr = 0; n_owner = 0; n_locked = 0; n_rsp_v = '0; n_rsp_d = '0; n_init = 1;
    end else begin
      n_ptr = m_ptr; n_owner = m_owner; n_locked = 0; n_rsp_v = '0; n_rsp_d = m_rsp_d;
      n_init = m_init;
      if (g >= 0) begin
        if (!(m_locked && g == m_owner && req_lock[g])) n_ptr = (g + 1) % N;
        n_locked = req_lock[g];
        if (req_lock[g]) n_owner = g;
        if (!req_write[g]) begin
          n_rsp_v[g] = 1'b1;
          n_rsp_d    = mem[id_a[g]];
        end
      end
    end
  end

  always @(posedge clk) begin
    m_ptr = n_ptr; m_owner = n_owner; m_locked = n_locked;
    m_rsp_v = n_rsp_v; m_rsp_d = n_rsp_d; m_init = n_init;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] ord [6];

  initial begin
    ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_lock = '0;
    for (int i = 0; i < N; i++) begin id_a[i] = '0; wd_a[i] = '0; end
    next_cycle(); next_cycle();
    rst_n = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle ready", 64'(req_ready), 64'd0);
      chk("idle rf_write", 64'(rf_write), 64'd0);
      chk("idle rf_read", 64'(rf_read), 64'd0);
      chk("idle rsp_valid", 64'(rsp_valid), 64'd0);
      next_cycle();
    end

    // Write r5 from requester 1, then read it back from requester 0.
    req_valid = 3'b010; req_write = 3'b010; id_a[1] = 4'd5; wd_a[1] = 64'h1234;
    @(negedge clk);
    chk("wr ready", 64'(req_ready), 64'b010);
    chk("wr rf_write", 64'(rf_write), 64'd1);
    chk("wr rf_id", 64'(rf_id), 64'd5);
    chk("wr rf_value", rf_value, 64'h1234);
    next_cycle();
    req_valid = 3'b001; req_write = '0; id_a[0] = 4'd5;
    @(negedge clk);
    chk("rd ready", 64'(req_ready), 64'b001);
    chk("rd rf_read", 64'(rf_read), 64'd1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("rd rsp_valid", 64'(rsp_valid), 64'b001);
    chk("rd rsp_data", rsp_data, 64'h1234);
    next_cycle();

    // Reset, then all three reading: strict rotation.
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    id_a[0] = 4'd1; id_a[1] = 4'd2; id_a[2] = 4'd3;
    req_valid = 3'b111; req_write = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr ready", 64'(req_ready), 64'(ord[k]));
      if (k > 0) begin
        chk("rr rsp_valid", 64'(rsp_valid), 64'(ord[k-1]));
        chk("rr rsp_data", rsp_data, 64'h1111 * (((k - 1) % 3) + 1));
      end
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    chk("rr last rsp_valid", 64'(rsp_valid), 64'b100);
    chk("rr last rsp_data", rsp_data, 64'h3333);
    chk("rr ptr", 64'(dut.rr_ptr_q), 64'd0);
    next_cycle();

    // Lock: requester 2 read-modify-writes r3 while 0 and 1 wait.
    req_valid = 3'b010;
    @(negedge clk);
    chk("pre ready", 64'(req_ready), 64'b010);
    next_cycle();
    req_valid = 3'b111; req_lock = 3'b100; id_a[0] = 4'd3; id_a[2] = 4'd3;
    @(negedge clk);
    chk("lock rd ready", 64'(req_ready), 64'b100);
    next_cycle();
    req_write = 3'b100; req_lock = '0; wd_a[2] = 64'hFF;
    @(negedge clk);
    chk("lock wr ready", 64'(req_ready), 64'b100);
    chk("lock state", 64'(dut.state_q), 64'(LOCKED));
    chk("lock wr rf_write", 64'(rf_write), 64'd1);
    chk("lock rsp_valid", 64'(rsp_valid), 64'b100);
    chk("lock rsp_data", rsp_data, 64'h3333);
    next_cycle();
    req_valid = 3'b011; req_write = '0;
    @(negedge clk);
    chk("unlock ready", 64'(req_ready), 64'b001);
    chk("unlock ptr", 64'(dut.rr_ptr_q), 64'd0);
    chk("unlock state", 64'(dut.state_q), 64'(ARB));
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("rmw rsp_valid", 64'(rsp_valid), 64'b001);
    chk("rmw rsp_data", rsp_data, 64'hFF);
    next_cycle();

    // Owner drops valid while locked: released the same cycle.
    req_valid = 3'b010; req_lock = 3'b010;
    @(negedge clk);
    chk("own1 ready", 64'(req_ready), 64'b010);
    next_cycle();
    req_valid = 3'b001; req_lock = '0;
    @(negedge clk);
    chk("drop ready", 64'(req_ready), 64'b001);
    chk("drop state before", 64'(dut.state_q), 64'(LOCKED));
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("drop state after", 64'(dut.state_q), 64'(ARB));
    next_cycle();

    // Reset while locked with a read requested.
    req_valid = 3'b100; req_lock = 3'b100;
    @(negedge clk);
    chk("own2 ready", 64'(req_ready), 64'b100);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst ready", 64'(req_ready), 64'd0);
    chk("rst rf_read", 64'(rf_read), 64'd0);
    next_cycle();
    rst_n = 1'b1; req_valid = '0; req_lock = '0;
    @(negedge clk);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst state", 64'(dut.state_q), 64'(ARB));
    chk("rst ptr", 64'(dut.rr_ptr_q), 64'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
